// File: rtl/intra_dec_pkg.sv
// Shared types and helpers for the intra reconstruction block dispatcher.
package intra_dec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ELIG,
    OFFER,
    WAIT,
    FIN
  } lane_state_e;

  typedef struct packed {
    logic [15:0] row_px;
    logic [15:0] col_px;
  } coord_t;

  localparam int CNT_W = 16;

  // Block index to pixel offset, truncated to the 16-bit coordinate field.
  function automatic logic [15:0] blk2px(input logic [15:0] idx, input logic [31:0] blk);
    logic [31:0] w_px;
    w_px = 32'(idx) * blk;
    return w_px[15:0];
  endfunction

endpackage

// File: rtl/intra_dec_lane.sv
// One dispatch lane: walks its own block rows and offers coordinates to one engine,
// gated by the peer lane's progress so the two rows form a wavefront.
module intra_dec_lane
  import intra_dec_pkg::*;
#(
  parameter int LANE_ID = 0,
  parameter int NCOLS   = 4,
  parameter int NROWS   = 3,
  parameter int BLK     = 4
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_fin_ack,
  input  logic        i_ready,
  input  logic        i_done,
  input  logic [15:0] i_peer_row,
  input  logic [15:0] i_peer_dcnt,
  output logic        o_valid,
  output logic [31:0] o_coord,
  output logic [15:0] o_row,
  output logic [15:0] o_dcnt,
  output logic        o_fin_next,
  output logic        o_done_err
);

  localparam logic [15:0] NCOLS_W  = 16'(NCOLS);
  localparam logic [15:0] NROWS_W  = 16'(NROWS);
  localparam logic [15:0] LANE_ROW = 16'(LANE_ID);
  localparam logic [31:0] BLK_W    = 32'(BLK);
  localparam bit          HAS_ROWS = (LANE_ID < NROWS);

  lane_state_e r_state, w_state_nxt;
  logic [15:0] r_row, r_col, r_dcnt;
  logic        r_valid;
  coord_t      r_coord;

  logic [15:0] w_need, w_ld_row, w_ld_col;
  logic        w_elig, w_last_col, w_last_blk, w_adv;

  // Top and top-right neighbours are done once the peer has left row r-1
  // or has completed enough blocks of it.
  always_comb begin
    w_need     = (r_col + 16'd2 > NCOLS_W) ? NCOLS_W : r_col + 16'd2;
    w_elig     = (r_row == 16'd0) ||
                 (i_peer_row >= r_row + 16'd1) ||
                 ((i_peer_row + 16'd1 == r_row) && (i_peer_dcnt >= w_need));
    w_last_col = (r_col == NCOLS_W - 16'd1);
    w_last_blk = w_last_col && (r_row + 16'd2 >= NROWS_W);
    w_adv      = (r_state == WAIT) && i_done;
    w_ld_row   = (r_state == IDLE) ? LANE_ROW : r_row;
    w_ld_col   = (r_state == IDLE) ? 16'd0 : r_col;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        // Row 0 needs no neighbours, so its first block is offered straight away.
        if (i_start) begin
          if (!HAS_ROWS)                w_state_nxt = FIN;
          else if (LANE_ROW == 16'd0)   w_state_nxt = OFFER;
          else                          w_state_nxt = ELIG;
        end
      end
      ELIG:    if (w_elig)  w_state_nxt = OFFER;
      OFFER:   if (i_ready) w_state_nxt = WAIT;
      WAIT:    if (i_done)  w_state_nxt = w_last_blk ? FIN : ELIG;
      FIN:     w_state_nxt = FIN;
      default: w_state_nxt = IDLE;
    endcase
    if (i_fin_ack) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row   <= '0;
      r_col   <= '0;
      r_dcnt  <= '0;
      r_valid <= 1'b0;
      r_coord <= '0;
    end else begin
      r_valid <= (w_state_nxt == OFFER);
      if ((r_state != OFFER) && (w_state_nxt == OFFER)) begin
        r_coord.row_px <= blk2px(w_ld_row, BLK_W);
        r_coord.col_px <= blk2px(w_ld_col, BLK_W);
      end
      if ((r_state == IDLE) && i_start) begin
        r_row  <= LANE_ROW;
        r_col  <= '0;
        r_dcnt <= '0;
      end else if (w_adv) begin
        if (w_last_col) begin
          r_col  <= '0;
          r_dcnt <= '0;
          r_row  <= r_row + 16'd2;
        end else begin
          r_col  <= r_col + 16'd1;
          r_dcnt <= r_dcnt + 16'd1;
        end
      end
    end
  end

  always_comb begin
    o_valid    = r_valid;
    o_coord    = r_coord;
    o_row      = r_row;
    o_dcnt     = r_dcnt;
    o_fin_next = (r_state == FIN) || (w_adv && w_last_blk);
    o_done_err = i_done && (r_state != WAIT);
  end

endmodule

// File: rtl/intra_dec_dispatch.sv
// Plane-level dispatcher: even block rows go to engine 0, odd rows to engine 1,
// with start/busy/frame_done control and a sticky protocol error flag.
module intra_dec_dispatch
  import intra_dec_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int BLK    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        issue_valid_e0,
  output logic        issue_valid_e1,
  input  logic        issue_ready_e0,
  input  logic        issue_ready_e1,
  output logic [31:0] issue_coord_e0,
  output logic [31:0] issue_coord_e1,
  input  logic        done_e0,
  input  logic        done_e1,
  output logic        busy,
  output logic        frame_done,
  output logic        proto_err
);

  localparam int NCOLS = WIDTH / BLK;
  localparam int NROWS = HEIGHT / BLK;

  logic [15:0] w_row0, w_row1, w_dcnt0, w_dcnt1;
  logic        w_fin0, w_fin1, w_err0, w_err1;
  logic        w_start_acc, w_fin_ack;
  logic        r_busy, r_frame_done, r_proto_err;

  assign w_start_acc = start && !r_busy;
  // Frame completes on the edge where both lanes are (or are about to be) finished.
  assign w_fin_ack   = r_busy && w_fin0 && w_fin1;

  intra_dec_lane #(
    .LANE_ID(0), .NCOLS(NCOLS), .NROWS(NROWS), .BLK(BLK)
  ) u_lane0 (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_start    (w_start_acc),
    .i_fin_ack  (w_fin_ack),
    .i_ready    (issue_ready_e0),
    .i_done     (done_e0),
    .i_peer_row (w_row1),
    .i_peer_dcnt(w_dcnt1),
    .o_valid    (issue_valid_e0),
    .o_coord    (issue_coord_e0),
    .o_row      (w_row0),
    .o_dcnt     (w_dcnt0),
    .o_fin_next (w_fin0),
    .o_done_err (w_err0)
  );

  intra_dec_lane #(
    .LANE_ID(1), .NCOLS(NCOLS), .NROWS(NROWS), .BLK(BLK)
  ) u_lane1 (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_start    (w_start_acc),
    .i_fin_ack  (w_fin_ack),
    .i_ready    (issue_ready_e1),
    .i_done     (done_e1),
    .i_peer_row (w_row0),
    .i_peer_dcnt(w_dcnt0),
    .o_valid    (issue_valid_e1),
    .o_coord    (issue_coord_e1),
    .o_row      (w_row1),
    .o_dcnt     (w_dcnt1),
    .o_fin_next (w_fin1),
    .o_done_err (w_err1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_frame_done <= w_fin_ack;
      if (w_start_acc)    r_busy <= 1'b1;
      else if (w_fin_ack) r_busy <= 1'b0;
      r_proto_err  <= r_proto_err || w_err0 || w_err1;
    end
  end

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_intra_dec_dispatch.sv
// Directed bench for intra_dec_dispatch on a 16x12 plane (and a 16x4 single-row plane).
module tb_intra_dec_dispatch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rdy0 = 1'b1, rdy1 = 1'b1;
  logic        done_e0 = 1'b0, done_e1 = 1'b0;
  logic        issue_valid_e0, issue_valid_e1, busy, frame_done, proto_err;
  logic [31:0] issue_coord_e0, issue_coord_e1;

  logic        start_b = 1'b0;
  logic        rdyb = 1'b1;
  logic        doneb0 = 1'b0, doneb1 = 1'b0;
  logic        vb0, vb1, busyb, fdb_o, perrb;
  logic [31:0] cb0, cb1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  intra_dec_dispatch #(.WIDTH(16), .HEIGHT(12), .BLK(4)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .issue_valid_e0(issue_valid_e0), .issue_valid_e1(issue_valid_e1),
    .issue_ready_e0(rdy0), .issue_ready_e1(rdy1),
    .issue_coord_e0(issue_coord_e0), .issue_coord_e1(issue_coord_e1),
    .done_e0(done_e0), .done_e1(done_e1),
    .busy(busy), .frame_done(frame_done), .proto_err(proto_err)
  );

  intra_dec_dispatch #(.WIDTH(16), .HEIGHT(4), .BLK(4)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_b),
    .issue_valid_e0(vb0), .issue_valid_e1(vb1),
    .issue_ready_e0(rdyb), .issue_ready_e1(rdyb),
    .issue_coord_e0(cb0), .issue_coord_e1(cb1),
    .done_e0(doneb0), .done_e1(doneb1),
    .busy(busyb), .frame_done(fdb_o), .proto_err(perrb)
  );

  int ncmp = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine models: record each transfer mid-cycle, answer with done one cycle later.
  logic [31:0] q0[$], q1[$], qb[$];
  int          c0[$], c1[$], d0[$], fd[$], db[$], fdb[$];
  logic        nxt0 = 1'b0, nxt1 = 1'b0, nxtb = 1'b0, man_done1 = 1'b0;
  int          nvb1 = 0;

  always begin
    @(negedge clk);
    if (issue_valid_e0 && rdy0) begin q0.push_back(issue_coord_e0); c0.push_back(cyc); nxt0 = 1'b1; end
    if (issue_valid_e1 && rdy1) begin q1.push_back(issue_coord_e1); c1.push_back(cyc); nxt1 = 1'b1; end
    if (done_e0)    d0.push_back(cyc);
    if (frame_done) fd.push_back(cyc);
    @(posedge clk);
    #1;
    done_e0 = nxt0 && reset;
    done_e1 = (nxt1 && reset) || man_done1;
    nxt0 = 1'b0;
    nxt1 = 1'b0;
  end

  always begin
    @(negedge clk);
    if (vb0 && rdyb) begin qb.push_back(cb0); nxtb = 1'b1; end
    if (vb1)    nvb1++;
    if (doneb0) db.push_back(cyc);
    if (fdb_o)  fdb.push_back(cyc);
    @(posedge clk);
    #1;
    doneb0 = nxtb && reset;
    nxtb = 1'b0;
  end

  task automatic start_plane(output int t);
    @(posedge clk); #1;
    start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_frame(input int base, input string tag);
    for (int i = 0; i < 300 && fd.size() <= base; i++) @(posedge clk);
    chk(tag, 32'(fd.size() > base), 32'd1);
  endtask

  logic [31:0] exp0[8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h80000, 32'h80004, 32'h80008, 32'h8000C};
  logic [31:0] exp1[4] = '{32'h40000, 32'h40004, 32'h40008, 32'h4000C};
  int          ec0[8]  = '{1, 4, 7, 10, 13, 16, 19, 22};
  int          ec1[4]  = '{7, 10, 13, 16};

  initial begin
    int t, bq0, bq1, bd0, bfd, n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid0", 32'(issue_valid_e0), 32'd0);
    chk("rst_valid1", 32'(issue_valid_e1), 32'd0);
    chk("rst_coord0", issue_coord_e0, 32'd0);
    chk("rst_coord1", issue_coord_e1, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Full plane, always-ready engines
    bq0 = q0.size(); bq1 = q1.size(); bd0 = d0.size(); bfd = fd.size();
    start_plane(t);
    @(negedge clk);
    chk("s1_busy_after_start", 32'(busy), 32'd1);
    wait_frame(bfd, "s1_frame_seen");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("s1_n_xfer0", 32'(q0.size() - bq0), 32'd8);
    chk("s1_n_xfer1", 32'(q1.size() - bq1), 32'd4);
    for (int i = 0; i < 8 && bq0 + i < q0.size(); i++) begin
      chk($sformatf("s1_coord0[%0d]", i), q0[bq0 + i], exp0[i]);
      chk($sformatf("s1_cyc0[%0d]", i), 32'(c0[bq0 + i] - t), 32'(ec0[i]));
    end
    for (int i = 0; i < 4 && bq1 + i < q1.size(); i++) begin
      chk($sformatf("s1_coord1[%0d]", i), q1[bq1 + i], exp1[i]);
      chk($sformatf("s1_cyc1[%0d]", i), 32'(c1[bq1 + i] - t), 32'(ec1[i]));
    end
    if (q1.size() > bq1 && d0.size() > bd0 + 1)
      chk("s1_lane1_first_vs_done2", 32'(c1[bq1] - d0[bd0 + 1]), 32'd2);
    chk("s1_n_frame_done", 32'(fd.size() - bfd), 32'd1);
    if (fd.size() > bfd) chk("s1_frame_done_cyc", 32'(fd[bfd] - t), 32'd24);
    chk("s1_busy_end", 32'(busy), 32'd0);
    chk("s1_proto_err", 32'(proto_err), 32'd0);

    // Engine 0 back-pressure for five cycles
    rdy0 = 1'b0;
    bq0 = q0.size(); bfd = fd.size();
    start_plane(t);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("s2_hold_valid[%0d]", i), 32'(issue_valid_e0), 32'd1);
      chk($sformatf("s2_hold_coord[%0d]", i), issue_coord_e0, 32'd0);
    end
    @(posedge clk); #1;
    rdy0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("s2_one_xfer", 32'(q0.size() - bq0), 32'd1);
    chk("s2_valid_dropped", 32'(issue_valid_e0), 32'd0);
    wait_frame(bfd, "s2_frame_seen");
    repeat (2) @(posedge clk);
    chk("s2_total_xfer0", 32'(q0.size() - bq0), 32'd8);

    // Stray done on lane 1 while it waits for eligibility
    bq1 = q1.size(); bfd = fd.size();
    start_plane(t);
    @(negedge clk);
    chk("s3_lane1_not_valid", 32'(issue_valid_e1), 32'd0);
    chk("s3_err_before", 32'(proto_err), 32'd0);
    man_done1 = 1'b1;
    @(posedge clk); #2;
    man_done1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("s3_err_set", 32'(proto_err), 32'd1);
    wait_frame(bfd, "s3_frame_seen");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("s3_err_sticky", 32'(proto_err), 32'd1);
    chk("s3_n_xfer1", 32'(q1.size() - bq1), 32'd4);
    for (int i = 0; i < 4 && bq1 + i < q1.size(); i++)
      chk($sformatf("s3_coord1[%0d]", i), q1[bq1 + i], exp1[i]);
    if (fd.size() > bfd) chk("s3_frame_done_cyc", 32'(fd[bfd] - t), 32'd24);

    // Reset in the middle of a plane, then restart
    bq0 = q0.size(); bq1 = q1.size();
    start_plane(t);
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(posedge clk);
      n = (q0.size() - bq0) + (q1.size() - bq1);
    end
    chk("s4_reached_5_xfers", 32'(n >= 5), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("s4_valid0", 32'(issue_valid_e0), 32'd0);
    chk("s4_valid1", 32'(issue_valid_e1), 32'd0);
    chk("s4_coord0", issue_coord_e0, 32'd0);
    chk("s4_coord1", issue_coord_e1, 32'd0);
    chk("s4_busy", 32'(busy), 32'd0);
    chk("s4_frame_done", 32'(frame_done), 32'd0);
    chk("s4_proto_err", 32'(proto_err), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    bq0 = q0.size(); bq1 = q1.size(); bfd = fd.size();
    start_plane(t);
    wait_frame(bfd, "s4_frame_seen");
    repeat (2) @(posedge clk);
    if (q0.size() > bq0) begin
      chk("s4_restart_coord", q0[bq0], 32'd0);
      chk("s4_restart_cyc", 32'(c0[bq0] - t), 32'd1);
    end
    chk("s4_restart_total", 32'((q0.size() - bq0) + (q1.size() - bq1)), 32'd12);
    chk("s4_restart_err", 32'(proto_err), 32'd0);

    // Single block row: lane 1 stays silent
    @(posedge clk); #1;
    start_b = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < 100 && fdb.size() == 0; i++) @(posedge clk);
    chk("s5_frame_seen", 32'(fdb.size() > 0), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("s5_lane1_never_valid", 32'(nvb1), 32'd0);
    chk("s5_n_xfer0", 32'(qb.size()), 32'd4);
    for (int i = 0; i < 4 && i < qb.size(); i++)
      chk($sformatf("s5_coord0[%0d]", i), qb[i], exp0[i]);
    if (fdb.size() > 0 && db.size() > 3) begin
      chk("s5_fd_after_done4", 32'(fdb[0] - db[3]), 32'd1);
      chk("s5_fd_cyc", 32'(fdb[0] - t), 32'd12);
    end
    chk("s5_n_frame_done", 32'(fdb.size()), 32'd1);
    chk("s5_busy_end", 32'(busyb), 32'd0);
    chk("s5_coord1_idle", cb1, 32'd0);
    chk("s5_proto_err", 32'(perrb), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
